cskip_adder_pipe: RTL and testbench



---
 rtl/cskip_pkg.sv | 41 ++++
 rtl/cskip_block.sv | 47 ++++
 rtl/cskip_adder_pipe.sv | 242 ++++++++++++++++++++++++
 tb/tb_cskip_adder_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cskip_pkg.sv
// -----------------------------------------------------------------------------
// cskip_pkg
// Shared definitions for the pipelined carry-skip adder.
//   - Default WIDTH / BLOCK / STAGES values.
//   - skip_block_count(): number of BLOCK-bit skip blocks across WIDTH bits.
//   - cfg_ok(): legality check for a WIDTH/BLOCK/STAGES combination.
//     WIDTH must split evenly into STAGES slices of whole skip blocks.
// -----------------------------------------------------------------------------
package cskip_pkg;

  localparam int unsigned CSKIP_WIDTH  = 32'd32;
  localparam int unsigned CSKIP_BLOCK  = 32'd4;
  localparam int unsigned CSKIP_STAGES = 32'd2;

  // Number of skip blocks needed to cover the full operand width.
  function automatic int unsigned skip_block_count(input int unsigned width,
                                                   input int unsigned block);
    return width / block;
  endfunction

  // True when the configuration divides into whole blocks per stage.
  function automatic bit cfg_ok(input int unsigned width,
                                input int unsigned block,
                                input int unsigned stages);
    bit ok;
    ok = 1'b1;
    if ((block == 32'd0) || (stages == 32'd0)) begin
      ok = 1'b0;
    end else if ((width % (block * stages)) != 32'd0) begin
      ok = 1'b0;
    end else if (stages > (width / block)) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  localparam bit CSKIP_DEFAULT_CFG_OK = cfg_ok(CSKIP_WIDTH, CSKIP_BLOCK, CSKIP_STAGES);

endpackage

// File: rtl/cskip_block.sv
// -----------------------------------------------------------------------------
// cskip_block
// Combinational BLOCK-bit ripple-carry adder with a carry-skip bypass.
// When every bit of the block propagates (a^b all ones) the block's carry-out
// equals its carry-in, so the carry is taken straight from cin instead of
// waiting for the ripple through the block.
//
// Ports:
//   a, b  [BLOCK-1:0]  operand slices
//   cin               carry into bit 0 of the block
//   sum   [BLOCK-1:0]  a + b + cin, low BLOCK bits
//   cout              carry out of the block (skip ? cin : ripple carry)
// -----------------------------------------------------------------------------
module cskip_block #(
  parameter int unsigned BLOCK = 32'd4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK-1:0] prop_s;
  logic             ripple_cout_s;
  logic             skip_s;

  assign prop_s = a ^ b;
  assign skip_s = &prop_s;

  // Bit-serial ripple through the block.
  always_comb begin : ripple
    logic c_v;
    c_v           = cin;
    sum           = {BLOCK{1'b0}};
    ripple_cout_s = 1'b0;
    for (int i = 0; i < int'(BLOCK); i++) begin
      sum[i] = prop_s[i] ^ c_v;
      c_v    = (a[i] & b[i]) | (prop_s[i] & c_v);
    end
    ripple_cout_s = c_v;
  end

  // Skip mux: a fully propagating block forwards its carry-in.
  assign cout = skip_s ? cin : ripple_cout_s;

endmodule

// File: rtl/cskip_adder_pipe.sv
// -----------------------------------------------------------------------------
// cskip_adder_pipe
// Parametrised, pipelined carry-skip adder with valid/ready flow control.
// Stage k adds operand bits [k*S +: S] (S = WIDTH/STAGES) using a chain of
// cskip_block instances, and registers: valid, carry out of the slice, the sum
// computed so far, and the operands for the remaining slices. The last stage
// register drives the outputs directly.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands on a/b/cin are valid
//   in_ready   adder accepts operands this cycle
//   a, b       [WIDTH-1:0] operands
//   cin        carry-in
//   out_valid  sum/cout valid
//   out_ready  consumer accepts the result this cycle
//   sum        [WIDTH-1:0] a+b+cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow flag (only when CSKIP_OVF_FLAG_EN is defined)
//
// Optional feature macro: CSKIP_OVF_FLAG_EN adds the registered ovf output.
// -----------------------------------------------------------------------------
module cskip_adder_pipe
  import cskip_pkg::*;
#(
  parameter int unsigned WIDTH  = CSKIP_WIDTH,
  parameter int unsigned BLOCK  = CSKIP_BLOCK,
  parameter int unsigned STAGES = CSKIP_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSKIP_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSTG       = int'(STAGES);
  localparam int S          = int'(WIDTH / STAGES);
  localparam int NBLK_TOTAL = int'(skip_block_count(WIDTH, BLOCK));
  localparam int NB         = NBLK_TOTAL / NSTG;

  generate
    if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_cfg_err
      $error("cskip_adder_pipe: WIDTH must be a multiple of BLOCK*STAGES");
    end
  endgenerate

  // Stage registers.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

  // Per-stage source values (inputs for stage 0, previous register otherwise).
  logic [STAGES-1:0] src_valid_s;
  logic [STAGES-1:0] src_c_s;
  logic [WIDTH-1:0]  src_a_s   [STAGES];
  logic [WIDTH-1:0]  src_b_s   [STAGES];
  logic [WIDTH-1:0]  src_sum_s [STAGES];

  // Per-stage slice results.
  logic [S-1:0]      slice_sum_s [STAGES];
  logic [STAGES-1:0] slice_cout_s;

  // Stage k may load this cycle.
  logic [STAGES-1:0] load_s;

`ifdef CSKIP_OVF_FLAG_EN
  logic ovf_q, ovf_d;
  logic ovf_slice_s;
`endif

  // Operands in the last stage have no further consumer; fold them into a sink.
  logic unused_last_ops_s;
  assign unused_last_ops_s = ^{a_q[STAGES-1], b_q[STAGES-1]};

  generate
    for (genvar k = 0; k < NSTG; k++) begin : g_stage
      logic [S-1:0] ssum_s;

      if (k == 0) begin : g_src_in
        assign src_valid_s[k] = in_valid;
        assign src_c_s[k]     = cin;
        assign src_a_s[k]     = a;
        assign src_b_s[k]     = b;
        assign src_sum_s[k]   = {WIDTH{1'b0}};
      end else begin : g_src_prev
        assign src_valid_s[k] = valid_q[k-1];
        assign src_c_s[k]     = carry_q[k-1];
        assign src_a_s[k]     = a_q[k-1];
        assign src_b_s[k]     = b_q[k-1];
        assign src_sum_s[k]   = sum_q[k-1];
      end

      // Skip blocks chained across this stage's slice.
      for (genvar j = 0; j < NB; j++) begin : g_blk
        logic blk_cin_s;
        logic blk_cout_s;

        if (j == 0) begin : g_c0
          assign blk_cin_s = src_c_s[k];
        end else begin : g_cn
          assign blk_cin_s = g_blk[j-1].blk_cout_s;
        end

        cskip_block #(
          .BLOCK (BLOCK)
        ) u_blk (
          .a    (src_a_s[k][k*S + j*int'(BLOCK) +: int'(BLOCK)]),
          .b    (src_b_s[k][k*S + j*int'(BLOCK) +: int'(BLOCK)]),
          .cin  (blk_cin_s),
          .sum  (ssum_s[j*int'(BLOCK) +: int'(BLOCK)]),
          .cout (blk_cout_s)
        );
      end

      assign slice_sum_s[k]  = ssum_s;
      assign slice_cout_s[k] = g_blk[NB-1].blk_cout_s;

`ifdef CSKIP_OVF_FLAG_EN
      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      if (k == NSTG - 1) begin : g_ovf
        assign ovf_slice_s = src_a_s[k][WIDTH-1] ^ src_b_s[k][WIDTH-1] ^
                             ssum_s[S-1] ^ slice_cout_s[k];
      end
`endif
    end
  endgenerate

  // Load enables, walked from the output back: a stage loads when it is empty
  // or its content moves on this cycle.
  always_comb begin : load_chain
    logic drain_v;
    load_s  = {STAGES{1'b0}};
    drain_v = out_ready;
    for (int k = NSTG - 1; k >= 0; k--) begin
      load_s[k] = !valid_q[k] || drain_v;
      drain_v   = load_s[k];
    end
  end

  assign in_ready = load_s[0];

  // Next-state for every stage register.
  always_comb begin : stage_next
    logic [WIDTH-1:0] merged_v;
    logic             zero_v;
    valid_d  = valid_q;
    carry_d  = carry_q;
    merged_v = {WIDTH{1'b0}};
    zero_v   = 1'b0;
    for (int k = 0; k < NSTG; k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
    end
    for (int k = 0; k < NSTG; k++) begin
      if (load_s[k]) begin
        merged_v            = src_sum_s[k];
        merged_v[k*S +: S]  = slice_sum_s[k];
        // Output-stage data is cleared when no result is loaded so the
        // outputs read 0 whenever out_valid is low.
        zero_v              = (k == NSTG - 1) && !src_valid_s[k];
        valid_d[k]          = src_valid_s[k];
        a_d[k]              = src_a_s[k];
        b_d[k]              = src_b_s[k];
        carry_d[k]          = zero_v ? 1'b0 : slice_cout_s[k];
        sum_d[k]            = zero_v ? {WIDTH{1'b0}} : merged_v;
      end else begin
        valid_d[k] = valid_q[k];
        carry_d[k] = carry_q[k];
        a_d[k]     = a_q[k];
        b_d[k]     = b_q[k];
        sum_d[k]   = sum_q[k];
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= {STAGES{1'b0}};
      carry_q <= {STAGES{1'b0}};
      for (int k = 0; k < NSTG; k++) begin
        a_q[k]   <= {WIDTH{1'b0}};
        b_q[k]   <= {WIDTH{1'b0}};
        sum_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 0; k < NSTG; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];

`ifdef CSKIP_OVF_FLAG_EN
  // Overflow flag follows the output-stage load, cleared with empty loads.
  always_comb begin
    ovf_d = ovf_q;
    if (load_s[STAGES-1]) begin
      ovf_d = src_valid_s[STAGES-1] ? ovf_slice_s : 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cskip_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_cskip_adder_pipe
// Self-checking bench for cskip_adder_pipe (WIDTH=32, BLOCK=4, STAGES=2).
// A queue of expected results computed with plain 33-bit addition is filled on
// every input transfer and drained on every output transfer. Directed cases
// pin literal results; a randomized phase exercises random valid/ready.
// -----------------------------------------------------------------------------
module tb_cskip_adder_pipe;

  localparam int STG = 2;
`ifdef CSKIP_OVF_FLAG_EN
  localparam logic [33:0] MASK = 34'h3_FFFF_FFFF;
`else
  localparam logic [33:0] MASK = 34'h1_FFFF_FFFF;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        dut_ovf;

  int checks   = 0;
  int failures = 0;

  logic [33:0] exp_q [$];
  logic        started   = 1'b0;
  logic        hold_pend = 1'b0;
  logic [33:0] hold_val  = 34'd0;
  logic        obs_valid;
  logic        obs_ready;
  logic [33:0] obs_got;
  int          n_out   = 0;
  int          run_len = 0;
  int          max_run = 0;

  cskip_adder_pipe #(
    .WIDTH  (32),
    .BLOCK  (4),
    .STAGES (STG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CSKIP_OVF_FLAG_EN
    ,
    .ovf       (dut_ovf)
`endif
  );

`ifndef CSKIP_OVF_FLAG_EN
  assign dut_ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: {signed overflow, carry out, 32-bit sum}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [32:0] t;
    logic        o;
    t = {1'b0, x} + {1'b0, y} + {32'd0, c};
    o = (x[31] == y[31]) && (t[31] != x[31]);
    return {o, t};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h7FFF_FFFF;
      3:       v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock: drive at negedge, observe 1ns later, account transfers.
  task automatic cycle(input logic r, input logic iv, input logic [31:0] ia,
                       input logic [31:0] ib, input logic ic, input logic ordy);
    logic [33:0] got;
    logic [33:0] e;
    @(negedge clk);
    rst = r; in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
    #1;
    got = {dut_ovf, cout, sum};
    if (started) begin
      if (!out_valid) check(got == 34'd0, "idle_zero", {30'd0, got}, 64'd0);
      if (hold_pend)
        check(out_valid && (got == hold_val), "hold_stable",
              {29'd0, out_valid, got}, {29'd0, 1'b1, hold_val});
    end
    obs_valid = out_valid;
    obs_ready = in_ready;
    obs_got   = got;
    if (out_valid) run_len++; else run_len = 0;
    if (run_len > max_run) max_run = run_len;
    if (r) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check(1'b0, "spurious_out", {30'd0, got}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check((got & MASK) == (e & MASK), "scoreboard", {30'd0, got}, {30'd0, e & MASK});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
      hold_pend = out_valid && !out_ready;
      hold_val  = got;
    end
    started = 1'b1;
  endtask

  task automatic wait_result(input logic [33:0] req, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      if (obs_valid) begin
        seen = 1'b1;
        check((obs_got & MASK) == (req & MASK), name, {30'd0, obs_got}, {30'd0, req & MASK});
      end
    end
    if (!seen) check(1'b0, name, 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++)
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check(exp_q.size() == 0, "drain_empty", 64'(exp_q.size()), 64'd0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    int acc0;
    int n0;
    rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; cin = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Single op after reset, with latency check.
    cycle(1'b0, 1'b1, 32'hA0A0_E1FF, 32'hA0BF_FFE0, 1'b0, 1'b1);
    check(obs_valid == 1'b0, "reset_out_valid", {63'd0, obs_valid}, 64'd0);
    check(obs_got == 34'd0, "reset_sum_cout", {30'd0, obs_got}, 64'd0);
    check(obs_ready == 1'b1, "reset_in_ready", {63'd0, obs_ready}, 64'd1);
    for (int i = 0; i < STG - 1; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      check(obs_valid == 1'b0, "latency_early", {63'd0, obs_valid}, 64'd0);
    end
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check(obs_valid == 1'b1, "latency_valid", {63'd0, obs_valid}, 64'd1);
    check(obs_got[32:0] == 33'h1_4160_E1DF, "single_op", {31'd0, obs_got[32:0]}, 64'h1_4160_E1DF);
    drain();

    // Full carry chain through the skip path.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    wait_result(34'h1_0000_0000, "carry_chain_cin");
    wait_result(34'h1_0000_0000, "carry_chain_b1");
    drain();

    // Streaming: 8 back-to-back ops.
    n0 = n_out; run_len = 0; max_run = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      check(obs_ready == 1'b1, "stream_in_ready", {63'd0, obs_ready}, 64'd1);
    end
    for (int i = 0; i < 20 && (n_out - n0) < 8; i++)
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check((n_out - n0) == 8, "stream_count", 64'(n_out - n0), 64'd8);
    check(max_run == 8, "stream_consecutive", 64'(max_run), 64'd8);
    drain();

    // Backpressure: out_ready low for 5 cycles with input offered.
    acc0 = exp_q.size();
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'b0);
    check((exp_q.size() - acc0) == STG, "bp_accepted", 64'(exp_q.size() - acc0), 64'(STG));
    check(obs_ready == 1'b0, "bp_in_ready_low", {63'd0, obs_ready}, 64'd0);
    drain();

    // Reset with two results in flight.
    cycle(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check(obs_valid == 1'b0, "midrst_out_valid", {63'd0, obs_valid}, 64'd0);
    check(obs_got == 34'd0, "midrst_sum", {30'd0, obs_got}, 64'd0);
    check(obs_ready == 1'b1, "midrst_in_ready", {63'd0, obs_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      check(obs_valid == 1'b0, "midrst_no_emit", {63'd0, obs_valid}, 64'd0);
    end

`ifdef CSKIP_OVF_FLAG_EN
    // Signed overflow flag.
    cycle(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    wait_result(34'h2_8000_0000, "ovf_set");
    wait_result(34'h1_0000_0000, "ovf_clear");
    drain();
`endif

    // Randomized valid/ready traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'b0, 1'($urandom_range(0, 9) < 7), rand_op(), rand_op(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
